// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single processor-side memory port.
// Round-robin with an optional lock; read data is routed back via a latency-matched owner tag pipeline.
module mem_port_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  logic              last_id;
  logic              locked;
  logic              a_wins_tie;
  logic              accept;
  logic              sel_id;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [RD_LAT:0]   tag_valid;
  logic [RD_LAT:0]   tag_id;

  // Handshake: a requester holds req/we/lock/addr/wdata stable until it sees
  // gnt high at a rising edge; that edge accepts the command. gnt is
  // combinational, at most one is high, and a command may be taken every cycle.
  always_comb begin
    a_wins_tie = locked ? (last_id == ID_A) : (last_id == ID_B);
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    if (!reset) begin
      a_gnt = a_req && (!b_req || a_wins_tie);
      b_gnt = b_req && !a_gnt;
    end
  end

  assign accept    = a_gnt | b_gnt;
  assign sel_id    = b_gnt ? ID_B : ID_A;
  assign sel_we    = b_gnt ? b_we : a_we;
  assign sel_lock  = b_gnt ? b_lock : a_lock;
  assign sel_addr  = b_gnt ? b_addr : a_addr;
  assign sel_wdata = b_gnt ? b_wdata : a_wdata;

  // Arbitration state only moves on a grant; a dropped lock holder keeps locked set.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_id <= ID_B;
      locked  <= 1'b0;
    end else if (accept) begin
      last_id <= sel_id;
      locked  <= sel_lock;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (accept) begin
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
      mem_we    <= sel_we;
    end else begin
      mem_we    <= 1'b0;
    end
  end

  // Stage k holds the tag of the command that was on mem_* k cycles ago.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= {tag_valid[RD_LAT-1:0], accept & ~sel_we};
      tag_id    <= {tag_id[RD_LAT-1:0], sel_id};
    end
  end

  assign a_rvalid = tag_valid[RD_LAT] && (tag_id[RD_LAT] == ID_A);
  assign b_rvalid = tag_valid[RD_LAT] && (tag_id[RD_LAT] == ID_B);
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a memory stand-in, a rule-level model checked every
// cycle on the falling edge, and directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0;
  logic              a_gnt, a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [DATA_W-1:0] b_wdata = '0;
  logic              b_gnt, b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // ---------------- memory stand-in ----------------
  logic [DATA_W-1:0] dev_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] shadow  [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];

  always @(posedge clk) begin
    rd_pipe[0] <= dev_mem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_we === 1'b1) dev_mem[mem_addr] = mem_wdata;
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) begin
      dev_mem[i] = DATA_W'(i) ^ 16'h5A5A;
      shadow[i]  = DATA_W'(i) ^ 16'h5A5A;
    end
    dev_mem[16'h0010] = 16'hBEEF; shadow[16'h0010] = 16'hBEEF;
    dev_mem[16'h0001] = 16'h1111; shadow[16'h0001] = 16'h1111;
    dev_mem[16'h0002] = 16'h2222; shadow[16'h0002] = 16'h2222;
    dev_mem[16'h0003] = 16'h3333; shadow[16'h0003] = 16'h3333;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [DATA_W-1:0] exp_q[$];
  int                due_q[$];
  bit                id_q[$];
  logic              m_last = 1'b1;
  logic              m_locked = 1'b0;
  logic              mem_known = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic              m_we = 1'b0;

  always @(negedge clk) begin
    logic ea, eb, erv_a, erv_b;
    logic [DATA_W-1:0] erd;
    erv_a = 1'b0;
    erv_b = 1'b0;
    erd   = '0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      erd = exp_q.pop_front();
      due_q.delete(0);
      if (id_q.pop_front()) erv_b = 1'b1;
      else                  erv_a = 1'b1;
    end
    chk("m_a_rvalid", 32'(a_rvalid), 32'(erv_a));
    chk("m_b_rvalid", 32'(b_rvalid), 32'(erv_b));
    if (erv_a) chk("m_a_rdata", 32'(a_rdata), 32'(erd));
    if (erv_b) chk("m_b_rdata", 32'(b_rdata), 32'(erd));
    if (mem_known) begin
      chk("m_mem_we", 32'(mem_we), 32'(m_we));
      chk("m_mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("m_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end

    if (reset) begin
      ea = 1'b0;
      eb = 1'b0;
    end else if (a_req && b_req) begin
      ea = m_locked ? (m_last == 1'b0) : (m_last == 1'b1);
      eb = !ea;
    end else begin
      ea = a_req;
      eb = b_req;
    end
    chk("m_a_gnt", 32'(a_gnt), 32'(ea));
    chk("m_b_gnt", 32'(b_gnt), 32'(eb));

    if (reset) begin
      m_last = 1'b1; m_locked = 1'b0;
      m_addr = '0; m_wdata = '0; m_we = 1'b0;
      exp_q.delete(); due_q.delete(); id_q.delete();
      mem_known = 1'b1;
    end else if (ea || eb) begin
      m_last   = eb;
      m_locked = eb ? b_lock : a_lock;
      m_addr   = eb ? b_addr : a_addr;
      m_wdata  = eb ? b_wdata : a_wdata;
      m_we     = eb ? b_we : a_we;
      if (m_we) shadow[m_addr] = m_wdata;
      else begin
        exp_q.push_back(shadow[m_addr]);
        due_q.push_back(cyc + 1 + RD_LAT);
        id_q.push_back(eb);
      end
    end else begin
      m_we = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic req, input logic we, input logic lock,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic lock,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wdata;
  endtask

  task automatic idle_all();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    nxt();
    reset = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    idle_all();
    repeat (n) nxt();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [DATA_W-1:0] d;
    do_reset();

    // Single A read from 0x0010 holding 0xBEEF.
    drive_a(1'b1, 1'b0, 1'b0, 15'h0010, '0);
    @(negedge clk);
    chk("t1_a_gnt", 32'(a_gnt), 32'd1);
    chk("t1_b_gnt", 32'(b_gnt), 32'd0);
    nxt(); idle_all();
    @(negedge clk);
    chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
    chk("t1_mem_we", 32'(mem_we), 32'd0);
    nxt();
    @(negedge clk);
    chk("t1_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("t1_a_rdata", 32'(a_rdata), 32'hBEEF);
    chk("t1_b_rvalid", 32'(b_rvalid), 32'd0);
    drain(2);

    // Continuous contention without lock alternates A,B,A,B,...
    do_reset();
    drive_a(1'b1, 1'b0, 1'b0, 15'h0100, '0);
    drive_b(1'b1, 1'b0, 1'b0, 15'h0200, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_a_gnt", 32'(a_gnt), 32'((i % 2) == 0));
      chk("t2_b_gnt", 32'(b_gnt), 32'((i % 2) == 1));
      if (i > 0) chk("t2_mem_addr", 32'(mem_addr), (i % 2) == 1 ? 32'h0100 : 32'h0200);
      nxt();
    end
    drain(3);

    // Locked write+read by A while B contends; B follows.
    drive_a(1'b1, 1'b1, 1'b1, 15'h7FFF, 16'h1234);
    drive_b(1'b1, 1'b0, 1'b0, 15'h0300, '0);
    @(negedge clk);
    chk("t3_a_gnt_wr", 32'(a_gnt), 32'd1);
    nxt();
    drive_a(1'b1, 1'b0, 1'b0, 15'h7FFF, '0);
    @(negedge clk);
    chk("t3_a_gnt_rd", 32'(a_gnt), 32'd1);
    chk("t3_mem_we", 32'(mem_we), 32'd1);
    chk("t3_mem_wdata", 32'(mem_wdata), 32'h1234);
    nxt();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t3_b_gnt", 32'(b_gnt), 32'd1);
    nxt();
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t3_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("t3_a_rdata", 32'(a_rdata), 32'h1234);
    drain(3);

    // Interleaved reads return in issue order to the right owner.
    drive_a(1'b1, 1'b0, 1'b0, 15'h0001, '0);
    nxt();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b1, 1'b0, 1'b0, 15'h0002, '0);
    nxt();
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    drive_a(1'b1, 1'b0, 1'b0, 15'h0003, '0);
    @(negedge clk);
    chk("t4_rv1_a", 32'(a_rvalid), 32'd1);
    chk("t4_rv1_b", 32'(b_rvalid), 32'd0);
    chk("t4_rd1", 32'(a_rdata), 32'h1111);
    nxt(); idle_all();
    @(negedge clk);
    chk("t4_rv2_a", 32'(a_rvalid), 32'd0);
    chk("t4_rv2_b", 32'(b_rvalid), 32'd1);
    chk("t4_rd2", 32'(b_rdata), 32'h2222);
    nxt();
    @(negedge clk);
    chk("t4_rv3_a", 32'(a_rvalid), 32'd1);
    chk("t4_rv3_b", 32'(b_rvalid), 32'd0);
    chk("t4_rd3", 32'(a_rdata), 32'h3333);
    drain(2);

    // Reset right after a read is accepted discards it.
    drive_b(1'b1, 1'b1, 1'b0, 15'h0050, 16'h5555);
    @(negedge clk);
    chk("t5_b_gnt", 32'(b_gnt), 32'd1);
    nxt();
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    drive_a(1'b1, 1'b0, 1'b0, 15'h0010, '0);
    @(negedge clk);
    chk("t5_a_gnt", 32'(a_gnt), 32'd1);
    chk("t5_mem_we_wr", 32'(mem_we), 32'd1);
    nxt();
    reset = 1'b1;
    drive_a(1'b1, 1'b0, 1'b0, 15'h0020, '0);
    drive_b(1'b1, 1'b0, 1'b0, 15'h0030, '0);
    @(negedge clk);
    chk("t5_rst_a_gnt", 32'(a_gnt), 32'd0);
    chk("t5_rst_b_gnt", 32'(b_gnt), 32'd0);
    chk("t5_rst_mem_addr", 32'(mem_addr), 32'h0010);
    nxt();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_post_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("t5_post_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("t5_post_mem_we", 32'(mem_we), 32'd0);
    chk("t5_post_mem_addr", 32'(mem_addr), 32'd0);
    chk("t5_post_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("t5_tie_a_gnt", 32'(a_gnt), 32'd1);
    chk("t5_tie_b_gnt", 32'(b_gnt), 32'd0);
    nxt();
    drain(3);

    // B-only write burst: one mem_we pulse per cycle, A never granted.
    for (int i = 0; i < 4; i++) begin
      d = 16'h0A0A + DATA_W'(i) * 16'h0101;
      drive_b(1'b1, 1'b1, 1'b0, 15'h0060 + ADDR_W'(i), d);
      @(negedge clk);
      chk("t6_b_gnt", 32'(b_gnt), 32'd1);
      chk("t6_a_gnt", 32'(a_gnt), 32'd0);
      if (i > 0) begin
        chk("t6_mem_we", 32'(mem_we), 32'd1);
        chk("t6_mem_addr", 32'(mem_addr), 32'h0060 + 32'(i - 1));
      end
      nxt();
    end
    idle_all();
    @(negedge clk);
    chk("t6_last_we", 32'(mem_we), 32'd1);
    chk("t6_last_addr", 32'(mem_addr), 32'h0063);
    chk("t6_last_wdata", 32'(mem_wdata), 32'h0D0D);
    nxt();
    @(negedge clk);
    chk("t6_we_drop", 32'(mem_we), 32'd0);
    nxt();
    drive_a(1'b1, 1'b0, 1'b0, 15'h0062, '0);
    nxt();
    idle_all();
    nxt();
    @(negedge clk);
    chk("t6_readback_rv", 32'(a_rvalid), 32'd1);
    chk("t6_readback", 32'(a_rdata), 32'h0C0C);
    drain(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
